// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned multiply / divide / modulo engine for the
// xcHa0s datapath. It runs beside the single-cycle ALU and stalls the control
// unit through `ready` while an iterative operation is in flight.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   opsel      - operation select from the control unit
//   srcA       - operand A (multiplicand / dividend)
//   srcB       - operand B (multiplier / divisor)
//   ready      - current instruction may retire this cycle
//   busy       - iterative operation in progress (BUSY or DONE)
//   result     - ACC value: MUL low product, DIV quotient, MOD remainder
//   result_hi  - X value:   MUL high product, DIV remainder, MOD quotient
//   flags      - {ZF, NF, CF, OF}
module muldiv_unit #(
    parameter logic [4:0] OP_MUL = 5'd13,
    parameter logic [4:0] OP_DIV = 5'd14,
    parameter logic [4:0] OP_MOD = 5'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  opsel,
    input  logic [15:0] srcA,
    input  logic [15:0] srcB,
    output logic        ready,
    output logic        busy,
    output logic [15:0] result,
    output logic [15:0] result_hi,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [4:0]  opsel_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [4:0]  cnt_q;
    // MUL: full 32-bit accumulator (multiplier starts in the low half).
    // DIV/MOD: low half holds the dividend, shifted out MSB-first while the
    // quotient bits are shifted in from the bottom.
    logic [31:0] acc_q;
    logic [15:0] rem_q;
    logic [15:0] result_q;
    logic [15:0] result_hi_q;
    logic [3:0]  flags_q;

    logic        start;
    logic        is_mul;
    logic        is_div;
    logic [16:0] mul_sum;
    logic [31:0] mul_next;
    logic [16:0] rem_sh;
    logic [15:0] rem_next;
    logic [15:0] quo_next;
    logic        mul_hi_nz;

    assign start  = (opsel == OP_MUL) || (opsel == OP_DIV) || (opsel == OP_MOD);
    assign is_mul = (opsel_q == OP_MUL);
    assign is_div = (opsel_q == OP_DIV);

    // One iteration of each algorithm, evaluated from the current registers.
    always_comb begin
        mul_sum  = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, a_q} : 17'd0);
        mul_next = {mul_sum, acc_q[15:1]};

        rem_sh   = {rem_q, acc_q[15]};
        rem_next = rem_sh[15:0];
        quo_next = {acc_q[14:0], 1'b0};
        if (rem_sh >= {1'b0, b_q}) begin
            // True difference is below b_q, so the low 16 bits are exact.
            rem_next    = rem_sh[15:0] - b_q;
            quo_next[0] = 1'b1;
        end

        mul_hi_nz = (mul_next[31:16] != 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            opsel_q     <= 5'd0;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            cnt_q       <= 5'd0;
            acc_q       <= 32'd0;
            rem_q       <= 16'd0;
            result_q    <= 16'd0;
            result_hi_q <= 16'd0;
            flags_q     <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        opsel_q <= opsel;
                        a_q     <= srcA;
                        b_q     <= srcB;
                        cnt_q   <= 5'd0;
                        rem_q   <= 16'd0;
                        acc_q   <= (opsel == OP_MUL) ? {16'd0, srcB} : {16'd0, srcA};
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (is_mul) begin
                        acc_q <= mul_next;
                    end else begin
                        acc_q <= {16'd0, quo_next};
                        rem_q <= rem_next;
                    end
                    if (cnt_q == 5'd15) begin
                        state_q <= StDone;
                        if (is_mul) begin
                            result_q    <= mul_next[15:0];
                            result_hi_q <= mul_next[31:16];
                            flags_q     <= {mul_next == 32'd0, mul_next[15], mul_hi_nz, mul_hi_nz};
                        end else if (is_div) begin
                            result_q    <= quo_next;
                            result_hi_q <= rem_next;
                            flags_q     <= {quo_next == 16'd0, quo_next[15], 1'b0, b_q == 16'd0};
                        end else begin
                            result_q    <= rem_next;
                            result_hi_q <= quo_next;
                            flags_q     <= {rem_next == 16'd0, rem_next[15], 1'b0, b_q == 16'd0};
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Idle ready is combinational so non-iterative ops retire with no stall;
    // it is gated by rst_n so the control unit never sees ready in reset.
    assign ready     = rst_n && (((state_q == StIdle) && !start) || (state_q == StDone));
    assign busy      = (state_q != StIdle);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [4:0] OpMul = 5'd13;
    localparam logic [4:0] OpDiv = 5'd14;
    localparam logic [4:0] OpMod = 5'd15;
    localparam logic [4:0] OpAdd = 5'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  opsel = OpAdd;
    logic [15:0] src_a = 16'd0;
    logic [15:0] src_b = 16'd0;
    logic        ready;
    logic        busy;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .OP_MUL(OpMul),
        .OP_DIV(OpDiv),
        .OP_MOD(OpMod)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opsel    (opsel),
        .srcA     (src_a),
        .srcB     (src_b),
        .ready    (ready),
        .busy     (busy),
        .result   (result),
        .result_hi(result_hi),
        .flags    (flags)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [15:0] rh, output logic [3:0] f);
        logic [31:0] p;
        logic [15:0] q;
        logic [15:0] m;
        if (op == OpMul) begin
            p  = 32'(a) * 32'(b);
            r  = p[15:0];
            rh = p[31:16];
            f  = {p == 32'd0, p[15], rh != 16'd0, rh != 16'd0};
        end else begin
            if (b == 16'd0) begin
                q = 16'hFFFF;
                m = a;
            end else begin
                q = a / b;
                m = a % b;
            end
            if (op == OpDiv) begin
                r  = q;
                rh = m;
            end else begin
                r  = m;
                rh = q;
            end
            f = {r == 16'd0, r[15], 1'b0, b == 16'd0};
        end
    endtask

    // Entered #1 after the negedge of cycle 0 with the op already applied.
    task automatic check_op(input string tag, input logic [4:0] op,
                            input logic [15:0] a, input logic [15:0] b);
        logic [15:0] er;
        logic [15:0] erh;
        logic [3:0]  ef;
        int bad;
        model(op, a, b, er, erh, ef);
        check_val({tag, " c0 ready"}, ready, 0);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            // Scramble inputs while busy; the engine must ignore them.
            opsel = OpMul + 5'($urandom_range(0, 2));
            src_a = 16'($urandom);
            src_b = 16'($urandom);
            #1;
            if (ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check_val({tag, " busy window"}, bad, 0);
        @(negedge clk);
        opsel = OpAdd;
        #1;
        check_val({tag, " c17 ready"}, ready, 1);
        check_val({tag, " c17 busy"}, busy, 1);
        check_val({tag, " result"}, result, er);
        check_val({tag, " result_hi"}, result_hi, erh);
        check_val({tag, " flags"}, flags, ef);
        @(negedge clk);
        #1;
        check_val({tag, " c18 idle"}, {ready, busy}, 2'b10);
        check_val({tag, " held"}, {result, result_hi, flags}, {er, erh, ef});
    endtask

    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        opsel = op;
        src_a = a;
        src_b = b;
        #1;
        check_op(tag, op, a, b);
    endtask

    initial begin
        logic [39:0] seen;
        logic [15:0] er;
        logic [15:0] erh;
        logic [3:0]  ef;
        logic [4:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;

        // Reset state with a non-iterative op presented: ready stays gated.
        #1;
        check_val("reset outputs", {ready, busy, result, result_hi, flags}, 37'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("add ready", ready, 1);
        check_val("add busy", busy, 0);

        // Directed cases.
        run_op("mul", OpMul, 16'h1234, 16'h0010);
        check_val("mul const", {result, result_hi, flags}, {16'h2340, 16'h0001, 4'b0011});
        run_op("div", OpDiv, 16'd100, 16'd7);
        check_val("div const", {result, result_hi, flags}, {16'h000E, 16'h0002, 4'b0000});
        run_op("div0", OpDiv, 16'h1234, 16'h0000);
        check_val("div0 const", {result, result_hi, flags}, {16'hFFFF, 16'h1234, 4'b0101});
        run_op("mod", OpMod, 16'hFFFF, 16'h0010);
        check_val("mod const", {result, result_hi, flags[3]}, {16'h000F, 16'h0FFF, 1'b0});
        run_op("modz", OpMod, 16'h0020, 16'h0010);
        check_val("modz const", {result, flags[3]}, {16'h0000, 1'b1});
        run_op("mulmax", OpMul, 16'hFFFF, 16'hFFFF);
        run_op("mulzero", OpMul, 16'h0000, 16'hBEEF);

        // Held MUL: restarts at cycles 0, 18, 36; ready only at 17 and 35.
        model(OpMul, 16'h00AB, 16'h0102, er, erh, ef);
        seen = 40'd0;
        @(negedge clk);
        opsel = OpMul;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 18 == 0) begin
                src_a = 16'h00AB;
                src_b = 16'h0102;
            end else begin
                src_a = 16'($urandom);
                src_b = 16'($urandom);
            end
            #1;
            seen[c] = ready;
            if (ready) check_val("b2b result", {result, result_hi}, {er, erh});
        end
        check_val("b2b pulses", seen, (40'd1 << 17) | (40'd1 << 35));
        opsel = OpAdd;
        repeat (20) @(negedge clk);

        // Randomized ops against the model.
        for (int i = 0; i < 30; i++) begin
            rop = OpMul + 5'($urandom_range(0, 2));
            ra  = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'd0;
                1: rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            run_op("rand", rop, ra, rb);
        end

        // Reset in cycle 8 of a DIV, after a completion left nonzero results.
        run_op("pre", OpMul, 16'h1234, 16'h0010);
        @(negedge clk);
        opsel = OpDiv;
        src_a = 16'd1000;
        src_b = 16'd3;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid reset", {ready, busy, result, result_hi, flags}, 37'd0);
        opsel = OpMul;
        src_a = 16'd3;
        src_b = 16'd5;
        @(negedge clk);
        #1;
        check_val("in reset", {ready, busy}, 2'b00);
        rst_n = 1'b1;
        #1;
        check_op("post reset", OpMul, 16'd3, 16'd5);
        check_val("post reset const", result, 16'h000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle unsigned multiply/divide/modulo engine sitting beside the single-cycle ALU in the xcHa0s datapath. It consumes the same `opsel`/operand buses the control unit drives, and produces the `ready` handshake that the control unit uses to gate PC advance, register writes and flag saves. For `MUL` it returns a 32-bit product as low half plus high half (high half goes to X). For `DIV`/`MOD` it returns quotient and remainder. For every other opcode it reports ready immediately.

## Interface
- `OP_MUL`, default 5'd13: `opsel` code of the ALU multiply; overridden at top level with the `opsel.v` value.
- `OP_DIV`, default 5'd14: `opsel` code of divide.
- `OP_MOD`, default 5'd15: `opsel` code of modulo.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opsel` input 5: operation select from the control unit.
- `srcA` input 16: operand A (multiplicand / dividend).
- `srcB` input 16: operand B (multiplier / divisor).
- `ready` output 1: the current instruction may retire this cycle.
- `busy` output 1: an iterative operation is in progress (BUSY or DONE state).
- `result` output 16: value for ACC. MUL gives the low product, DIV the quotient, MOD the remainder.
- `result_hi` output 16: value for X (the extra write). MUL gives the high product, DIV the remainder, MOD the quotient.
- `flags` output 4: {ZF, NF, CF, OF}, bit 3 down to bit 0.

## Operation
- The start condition is `opsel` ∈ {OP_MUL, OP_DIV, OP_MOD}.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**
  - If no start condition: `ready` = 1 (combinational), `busy` = 0.
  - On a start condition: `ready` = 0. Latch `srcA`, `srcB` and the op, clear the 5-bit step counter, and go to BUSY.
- **BUSY**
  - One iteration per cycle, 16 iterations. The counter runs 0..15; after step 15 go to DONE.
  - `ready` = 0, `busy` = 1.
  - Input changes on `opsel`, `srcA` and `srcB` are ignored here.
- **DONE**
  - `ready` = 1 for exactly one cycle, `busy` = 1.
  - Results and flags are driven from registers. Next state is IDLE unconditionally.
  - IDLE re-evaluates `opsel`, so an identical back-to-back instruction restarts the operation.
- **Multiply**: shift-add over a 32-bit accumulator. Each step examines the multiplier LSB, conditionally adds the multiplicand into the upper half, then shifts right by 1.
- **Divide/modulo**: restoring division with a 17-bit partial remainder. Each step:
  - Shift in the next dividend bit.
  - If R ≥ B, subtract B and set the quotient bit to 1.
- **Divide by zero**: no special path. The algorithm naturally yields quotient 16'hFFFF and remainder = dividend. The OF flag is set, and latency is unchanged.
- **Flags**, computed at the transition into DONE and held until the next completion:
  - MUL: ZF = (32-bit product == 0), NF = product[15], CF = OF = (product[31:16] != 0).
  - DIV: ZF = (quotient == 0), NF = quotient[15], CF = 0, OF = (divisor == 0).
  - MOD: ZF = (remainder == 0), NF = remainder[15], CF = 0, OF = (divisor == 0).
- All arithmetic is unsigned. There is no truncation other than splitting into the 16-bit halves.

## Timing
- **Reset values**
  - While `rst_n` = 0: `ready` = 0, `busy` = 0, `result` = 0, `result_hi` = 0, `flags` = 0, state = IDLE, counter = 0.
  - `ready` is gated low during reset.
- **Latency**
  - Op presented in IDLE during cycle 0. BUSY runs cycles 1–16. `ready` = 1 in cycle 17.
  - Total is 18 cycles including the IDLE start cycle.
  - Back-to-back multi-cycle instructions produce `ready` pulses 18 cycles apart.
- **Non-iterative opcodes**: `ready` = 1 in the same cycle (zero added latency). The control unit is never stalled for them.
- **Reset mid-operation**: asserting `rst_n` low at any state aborts immediately. No partial result becomes visible, and outputs return to reset values. After release, a pending start begins a full 18-cycle operation.
- `result`, `result_hi` and `flags` are stable from DONE until the next DONE. They are not cleared on return to IDLE.

## Test plan
- **MUL**: `srcA`=16'h1234, `srcB`=16'h0010.
  - `ready` low for cycles 0–16, high only in cycle 17.
  - `result`=16'h2340, `result_hi`=16'h0001, `flags`=4'b0011.
- **DIV**: 100 / 7 gives `result`=16'h000E, `result_hi`=16'h0002, `flags`=4'b0000, `ready` in cycle 17.
- **Divide by zero**: DIV 16'h1234 / 0 gives `result`=16'hFFFF, `result_hi`=16'h1234, `flags`=4'b0101, with the same 17-cycle latency.
- **MOD**: 16'hFFFF % 16'h0010 gives `result`=16'h000F, `result_hi`=16'h0FFF, ZF=0.
  - A second case, 16'h0020 % 16'h0010, gives `result`=0 and ZF=1.
- **Non-iterative op and back-to-back restart**:
  - `opsel`=ALU add gives `ready`=1 and `busy`=0 in the same cycle.
  - MUL held for 40 cycles with fixed operands gives `ready` pulses at cycles 17 and 35 only, with operand changes during BUSY ignored.
- **Reset mid-operation**:
  - Pulse `rst_n` low in cycle 8 of a DIV: all outputs go to 0 immediately.
  - After release with MUL 3×5 presented, `ready` arrives 17 cycles later with `result`=16'h000F.
